// File: rtl/result_readback_pkg.sv
// Shared definitions for the result readback path.
// Holds the FSM state encodings and the default widths/depths used by
// result_readback and its output FIFO.
package result_readback_pkg;

  localparam int RR_ADDR_W = 12;
  localparam int RR_RES_W  = 32;
  localparam int RR_FIFO_D = 4;

  localparam logic [2:0] RR_IDLE  = 3'd0;
  localparam logic [2:0] RR_WAIT  = 3'd1;
  localparam logic [2:0] RR_READ  = 3'd2;
  localparam logic [2:0] RR_DRAIN = 3'd3;
  localparam logic [2:0] RR_DONE  = 3'd4;

endpackage

// File: rtl/result_readback_fifo.sv
// rr_sync_fifo: small synchronous FIFO used as the output buffer of
// result_readback. A push and a pop in the same cycle are both honoured.
// Ports:
//   clk, rst   clock and synchronous active-high reset (pointers/count only)
//   push       write push_data this cycle (caller guarantees not full)
//   push_data  word to store
//   pop        drop the head word this cycle (caller guarantees not empty)
//   head       word at the head of the FIFO
//   cnt        current occupancy, 0..DEPTH
//   empty      cnt == 0
module rr_sync_fifo
  import result_readback_pkg::*;
#(
  parameter int DEPTH = RR_FIFO_D,
  parameter int WIDTH = RR_RES_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; stale contents are never visible because the
  // consumer only looks at head while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);

endmodule

// File: rtl/result_readback.sv
// result_readback: drains a block of result words from RAM port B once the
// result writer has finished, and streams them out over valid/ready with a
// last-beat marker.
// Ports:
//   clk, rstn   clock; rstn is a synchronous ACTIVE-HIGH reset
//   w_done      writer finished (pulse or level), remembered in wr_flag
//   start       request a readback, sampled only while idle
//   base_addr   first RAM address of the block (captured on start)
//   count       number of words in the block (captured on start)
//   rd_en       RAM port-B read enable
//   rd_addr     RAM port-B address
//   rd_data     RAM read data, valid one cycle after rd_en
//   m_valid     output word valid
//   m_ready     downstream ready
//   m_data      output word
//   m_last      marks the final word of the block
//   busy        high whenever the FSM is not idle
//   done        one-cycle pulse when the block is complete
module result_readback
  import result_readback_pkg::*;
#(
  parameter int ADDR_W = RR_ADDR_W,
  parameter int RES_W  = RR_RES_W,
  parameter int FIFO_D = RR_FIFO_D
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              w_done,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RES_W-1:0]  rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [RES_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_D) + 1;
  localparam int NW = ADDR_W + 1;

  logic [2:0]        state, state_nxt;
  logic              wr_flag;
  logic [ADDR_W-1:0] base_r;
  logic [NW-1:0]     count_r;
  logic [NW-1:0]     issued;
  logic [NW-1:0]     sent;
  logic              vld_p1;
  logic              pop;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic [RES_W-1:0]  fifo_head;
  logic [CW:0]       occ_nxt;

  assign pop = m_valid & m_ready;

  // Credits: FIFO words plus the read already in flight, after this cycle's
  // pop. A new read is allowed only if its word is guaranteed a slot.
  assign occ_nxt = (CW+1)'(fifo_cnt) + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign rd_en   = (state == RR_READ) && (occ_nxt < (CW+1)'(FIFO_D));
  assign rd_addr = base_r + issued[ADDR_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      RR_IDLE: begin
        if (start) begin
          if (count == '0)            state_nxt = RR_DONE;
          else if (wr_flag || w_done) state_nxt = RR_READ;
          else                        state_nxt = RR_WAIT;
        end
      end
      RR_WAIT:  if (wr_flag || w_done) state_nxt = RR_READ;
      RR_READ:  if (rd_en && (issued + NW'(1) == count_r)) state_nxt = RR_DRAIN;
      // All beats accepted implies the FIFO is empty and nothing is in flight.
      RR_DRAIN: if (sent + NW'(pop) == count_r) state_nxt = RR_DONE;
      RR_DONE:  state_nxt = RR_IDLE;
      default:  state_nxt = RR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= RR_IDLE;
      wr_flag <= 1'b0;
      base_r  <= '0;
      count_r <= '0;
      issued  <= '0;
      sent    <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= rd_en;
      // Clear on entry to DONE wins over a simultaneous w_done.
      if (state_nxt == RR_DONE && state != RR_DONE) wr_flag <= 1'b0;
      else if (w_done)                              wr_flag <= 1'b1;
      if (state == RR_IDLE && start) begin
        base_r  <= base_addr;
        count_r <= {1'b0, count};
        issued  <= '0;
        sent    <= '0;
      end else begin
        if (rd_en) issued <= issued + NW'(1);
        if (pop)   sent   <= sent + NW'(1);
      end
    end
  end

  // ---- stage p1: RAM word lands, pushed straight into the output FIFO ----
  rr_sync_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rstn),
    .push      (vld_p1),
    .push_data (rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .cnt       (fifo_cnt),
    .empty     (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head : '0;
  assign m_last  = m_valid && (sent == count_r - NW'(1));
  assign busy    = (state != RR_IDLE);
  assign done    = (state == RR_DONE);

endmodule

// File: tb/tb_result_readback.sv
module tb_result_readback;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        w_done = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [11:0] count = '0;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  result_readback #(.ADDR_W(12), .RES_W(32), .FIFO_D(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .w_done    (w_done),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [11:0] a);
    return 32'h5A00_0000 | {8'h00, a, 12'h000} | {20'h00000, a ^ 12'hFFF};
  endfunction

  // RAM port B: one-cycle read latency
  always @(posedge clk) if (rd_en) rd_data <= ram_word(rd_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_fn(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return cyc[0];
    if (cyc < 12) return cyc[0];
    if (cyc < 22) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    logic [11:0] base;
    int          n;
    int          mode;     // 0 ready high, 1 toggle, 2 toggle then 10-cycle stall
    bit          pre;      // pulse w_done before start
    int          wd_at;    // cycle of w_done pulse inside the run, -1 none
    int          ign_at;   // cycle of an extra start while busy, -1 none
    int          exp_fv;   // cycle of first m_valid
    int          exp_done; // cycle of done when n==0
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  task automatic run_block(input vec_t v);
    int nrd = 0, nbeat = 0, nlast = 0, ndone = 0, nvalid = 0;
    int fv_cyc = -1, last_cyc = -1, done_cyc = -1, wait_viol = 0, max_occ = 0;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0, got_first = '0, got_last = '0;
    if (v.pre) begin
      @(negedge clk);
      w_done = 1'b1; start = 1'b0;
    end
    for (int cyc = 0; cyc < 300 && ndone == 0; cyc++) begin
      @(negedge clk);
      start  = (cyc == 0) || (cyc == v.ign_at);
      w_done = (cyc == v.wd_at);
      if (cyc == 0) begin base_addr = v.base; count = 12'(v.n); end
      if (cyc == v.ign_at) begin base_addr = 12'hABC; count = 12'd1; end
      m_ready = ready_fn(v.mode, cyc);
      #1;
      if (!v.pre && v.wd_at > 0 && cyc >= 1 && cyc <= v.wd_at)
        if (rd_en || !busy) wait_viol++;
      if (rd_en) begin
        check("rd_addr", rd_addr, 12'(v.base + 12'(nrd)));
        nrd++;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (m_valid) begin
        nvalid++;
        if (fv_cyc < 0) fv_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        check("beat_data", m_data, ram_word(12'(v.base + 12'(nbeat))));
        check("beat_last", m_last, (nbeat == v.n - 1));
        if (nbeat == 0) got_first = m_data;
        got_last = m_data;
        if (m_last) nlast++;
        nbeat++;
        last_cyc = cyc;
      end
      if (nrd - nbeat > max_occ) max_occ = nrd - nbeat;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) begin ndone++; done_cyc = cyc; end
    end
    start = 1'b0; w_done = 1'b0;
    check("beats", nbeat, v.n);
    check("reads", nrd, v.n);
    check("done_pulses", ndone, 1);
    check("occupancy_ok", (max_occ <= 4), 1);
    if (v.n > 0) begin
      check("first_word", got_first, v.exp_first);
      check("last_word", got_last, v.exp_last);
      check("last_marks", nlast, 1);
      check("first_valid_cyc", fv_cyc, v.exp_fv);
      check("done_after_last", done_cyc - last_cyc, 1);
    end else begin
      check("zero_valids", nvalid, 0);
      check("zero_done_cyc", done_cyc, v.exp_done);
    end
    if (!v.pre && v.wd_at > 0) check("wait_idle_reads", wait_viol, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    int nb;
    int viol;
    vecs[0] = '{12'h010, 8,  0, 1'b1, -1, -1, 3,  -1, 32'h5A010FEF, 32'h5A017FE8};
    vecs[1] = '{12'h000, 4,  0, 1'b0, 20, -1, 23, -1, 32'h5A000FFF, 32'h5A003FFC};
    vecs[2] = '{12'h200, 16, 2, 1'b1, -1, -1, 3,  -1, 32'h5A200DFF, 32'h5A20FDF0};
    vecs[3] = '{12'h123, 0,  0, 1'b1, -1, -1, -1, 1,  32'h0,        32'h0};
    vecs[4] = '{12'hFFE, 4,  0, 1'b1, -1, -1, 3,  -1, 32'h5AFFE001, 32'h5A001FFE};
    vecs[5] = '{12'h040, 6,  0, 1'b1, 5,  4,  3,  -1, 32'h5A040FBF, 32'h5A045FBA};
    vecs[6] = '{12'h050, 2,  0, 1'b0, 8,  -1, 11, -1, 32'h5A050FAF, 32'h5A051FAE};

    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_outputs_zero("reset");

    for (int i = 0; i < 7; i++) run_block(vecs[i]);

    // Reset during the fifth beat of a 16-word block
    @(negedge clk);
    w_done = 1'b1;
    @(negedge clk);
    w_done = 1'b0; start = 1'b1; base_addr = 12'h100; count = 12'd16; m_ready = 1'b1;
    nb = 0;
    for (int cyc = 0; cyc < 60 && !rstn; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 1) start = 1'b0;
      #1;
      if (m_valid && nb == 4) rstn = 1'b1;
      else if (m_valid && m_ready) nb++;
    end
    check("rst_reached_beat5", rstn, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_outputs_zero("midrst");
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (done || m_valid || busy) viol++;
    end
    check("post_rst_quiet", viol, 0);
    run_block('{12'h300, 3, 0, 1'b1, -1, -1, 3, -1, 32'h5A300CFF, 32'h5A302CFD});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
